// File: rtl/trng_multi_collector.sv
// Multi-channel TRNG bit collector: picks one channel (or the XOR of all of them),
// decimates, packs bits into words and stores them in a one-shot or ring buffer.
module trng_multi_collector #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic               cfg_xor,
    input  logic [CH_W-1:0]    cfg_ch_sel,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic [ADDR_W:0]    cfg_count,
    input  logic [NUM_CH-1:0]  random_bits,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [ADDR_W:0]    word_count,
    output logic [ADDR_W-1:0]  wr_ptr,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [WORD_W-1:0]  rd_data,
    output logic               rd_valid
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(WORD_W - 1);
    localparam logic [CH_W:0]     NUM_CH_C  = (CH_W+1)'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

    state_e              state_q;
    logic                start_prev_q;
    logic                mode_q, xor_q;
    logic [CH_W-1:0]     ch_sel_q;
    logic [DECIM_W-1:0]  decim_q, decim_cnt_q;
    logic [ADDR_W:0]     target_q, word_count_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [WORD_W-1:0]   shift_q;
    logic [BC_W-1:0]     bit_cnt_q;
    logic                busy_q, done_q, overflow_q;
    logic [WORD_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    logic                start_edge, src_bit, accept, word_wr, hit_tgt;
    logic [WORD_W-1:0]   shift_d;
    logic [ADDR_W:0]     wc_d, target_d;
    logic [ADDR_W-1:0]   ptr_d;

    logic [WORD_W-1:0]   mem [0:DEPTH-1];

    assign start_edge = start & ~start_prev_q;

    always_comb begin
        src_bit = random_bits[0];
        if (xor_q)
            src_bit = ^random_bits;
        else if ({1'b0, ch_sel_q} < NUM_CH_C)
            src_bit = random_bits[ch_sel_q];

        accept   = (state_q == S_COLLECT) && (decim_cnt_q == decim_q);
        word_wr  = accept && (bit_cnt_q == LAST_BIT);
        shift_d  = {shift_q[WORD_W-2:0], src_bit};
        wc_d     = (word_count_q == DEPTH_C) ? word_count_q : word_count_q + 1'b1;
        ptr_d    = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        hit_tgt  = !mode_q && (wc_d == target_q);
        // A zero or oversized target means "fill the whole buffer".
        target_d = ((cfg_count == '0) || (cfg_count > DEPTH_C)) ? DEPTH_C : cfg_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            mode_q       <= 1'b0;
            xor_q        <= 1'b0;
            ch_sel_q     <= '0;
            decim_q      <= '0;
            decim_cnt_q  <= '0;
            target_q     <= '0;
            word_count_q <= '0;
            wr_ptr_q     <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            start_prev_q <= start;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        mode_q       <= cfg_mode;
                        xor_q        <= cfg_xor;
                        ch_sel_q     <= cfg_ch_sel;
                        decim_q      <= cfg_decim;
                        target_q     <= target_d;
                        done_q       <= 1'b0;
                        overflow_q   <= 1'b0;
                        word_count_q <= '0;
                        wr_ptr_q     <= '0;
                        shift_q      <= '0;
                        bit_cnt_q    <= '0;
                        decim_cnt_q  <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    decim_cnt_q <= accept ? '0 : decim_cnt_q + 1'b1;
                    if (accept) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= word_wr ? '0 : bit_cnt_q + 1'b1;
                    end
                    if (word_wr) begin
                        wr_ptr_q     <= ptr_d;
                        word_count_q <= wc_d;
                        if (mode_q && (word_count_q == DEPTH_C))
                            overflow_q <= 1'b1;
                        if (hit_tgt)
                            done_q <= 1'b1;
                    end
                    // The final write still lands when it coincides with an abort.
                    if (!start) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (word_wr && hit_tgt) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_wr)
            mem[wr_ptr_q[MEM_AW-1:0]] <= shift_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr[MEM_AW-1:0]] : '0;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
    assign wr_ptr     = wr_ptr_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_trng_multi_collector.sv
// Randomised bench for trng_multi_collector: a bit-stream model predicts status and
// buffer contents; a read monitor checks rd_data against a queue of expected words.
module tb_trng_multi_collector;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cfg_mode = 1'b0, cfg_xor = 1'b0;
    logic [1:0] cfg_ch_sel = '0;
    logic [7:0] cfg_decim = '0;
    logic [5:0] cfg_count = '0;
    logic [3:0] random_bits = '0;
    logic       busy, done, overflow;
    logic [5:0] word_count;
    logic [4:0] wr_ptr;
    logic       rd_en = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;

    trng_multi_collector #(.NUM_CH(4), .CH_W(2), .WORD_W(8), .DEPTH(DEPTH),
                           .ADDR_W(5), .DECIM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_xor(cfg_xor),
        .cfg_ch_sel(cfg_ch_sel), .cfg_decim(cfg_decim), .cfg_count(cfg_count),
        .random_bits(random_bits), .busy(busy), .done(done), .overflow(overflow),
        .word_count(word_count), .wr_ptr(wr_ptr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: words written this run, config, and buffer image.
    int       m_words = 0, m_target = DEPTH;
    bit       m_mode = 0;
    logic [7:0] m_mem [DEPTH];
    bit       m_vld [DEPTH];

    typedef struct { int data; int due; } rd_exp_t;
    rd_exp_t exp_q[$];
    rd_exp_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input int exp_busy);
        chk("busy", busy, exp_busy);
        chk("done", done, (!m_mode && m_words == m_target) ? 1 : 0);
        chk("overflow", overflow, (m_mode && m_words > DEPTH) ? 1 : 0);
        chk("word_count", word_count, (m_words > DEPTH) ? DEPTH : m_words);
        chk("wr_ptr", wr_ptr, m_words % DEPTH);
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                checks++; failures++;
                $display("FAIL rd_valid unexpected act=1 exp=0 cyc=%0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", rd_data, mon_e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            void'(exp_q.pop_front());
            checks++; failures++;
            $display("FAIL rd_valid missing act=0 exp=1 cyc=%0d", cyc);
        end
    end

    task automatic rd(input int a);
        rd_exp_t e;
        rd_en = 1'b1;
        rd_addr = 5'(a);
        e.data = (a >= DEPTH) ? 0 : int'(m_mem[a]);
        e.due = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) if (m_vld[a]) rd(a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rd_pending", exp_q.size(), 0);
    endtask

    // pat: 0 random, 1 0xA5 MSB-first on the selected channel, 2 odd parity on accept cycles.
    task automatic run(input bit mode, input bit xr, input int sel, input int decim,
                       input int count, input int ncyc, input int pat, input bit stop_rst);
        logic [7:0] a5 = 8'hA5;
        logic [7:0] sh = '0;
        logic [3:0] rb;
        int nbits = 0;
        bit coll = 1, acc;
        cfg_mode = mode; cfg_xor = xr; cfg_ch_sel = 2'(sel);
        cfg_decim = 8'(decim); cfg_count = 6'(count);
        start = 1'b1;
        @(posedge clk); #1;
        m_words = 0; m_mode = mode;
        m_target = (count == 0 || count > DEPTH) ? DEPTH : count;
        for (int k = 0; k < ncyc; k++) begin
            acc = ((k + 1) % (decim + 1)) == 0;
            rb = 4'($urandom);
            if (acc && pat == 1) rb[sel] = a5[7 - (nbits % 8)];
            if (acc && pat == 2 && ^rb == 1'b0) rb[0] = ~rb[0];
            random_bits = rb;
            if (k == ncyc - 1 && !stop_rst) start = 1'b0;
            @(negedge clk);
            check_status(coll ? 1 : 0);
            if (coll && acc) begin
                sh = {sh[6:0], xr ? ^rb : rb[sel]};
                nbits++;
                if (nbits % 8 == 0) begin
                    m_mem[m_words % DEPTH] = sh;
                    m_vld[m_words % DEPTH] = 1;
                    m_words++;
                    if (!mode && m_words == m_target) coll = 0;
                end
            end
            @(posedge clk); #1;
        end
        if (!stop_rst) begin
            @(negedge clk);
            check_status(0);
        end else begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_wr_ptr", wr_ptr, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_rd_valid", rd_valid, 0);
            start = 1'b0;
            m_words = 0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, dec;
        #23;
        check_status(0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_valid", rd_valid, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // One-shot, 4 words of 0xA5 from channel 2.
        run(0, 0, 2, 0, 4, 40, 1, 0);
        read_all();
        for (int a = 0; a < 4; a++) chk("a5_model", m_mem[a], 8'hA5);
        // XOR of all channels with decimation by 3; accepted XOR always 1.
        run(0, 1, 0, 2, 2, 60, 2, 0);
        read_all();
        chk("xor_word", m_mem[0], 8'hFF);
        // Ring mode, 20 words exactly.
        run(1, 0, $urandom_range(0, 3), 0, 0, 160, 0, 0);
        read_all();
        // Abort after 3 words plus 5 bits.
        run(0, 0, $urandom_range(0, 3), 0, 10, 29, 0, 0);
        read_all();
        // Zero and oversized targets fill the buffer.
        run(0, 0, $urandom_range(0, 3), 0, 0, 140, 0, 0);
        run(0, 1, 0, 0, 20, 140, 0, 0);
        read_all();
        rd(17);
        @(posedge clk); #1;
        // Async reset mid-word, then a fresh collection.
        run(0, 0, 1, 0, 8, 13, 0, 1);
        run(0, 0, $urandom_range(0, 3), 1, 3, 60, 0, 0);
        read_all();
        // Random configurations.
        for (int i = 0; i < 4; i++) begin
            cnt = $urandom_range(1, 16);
            dec = $urandom_range(0, 3);
            run(1'($urandom), 1'($urandom), $urandom_range(0, 3), dec, cnt,
                $urandom_range(10, cnt * 8 * (dec + 1) + 10), 0, 0);
            read_all();
        end
        chk("rd_pending_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trng_multi_collector.md
Name: trng_multi_collector

Overview:
- Parametrised successor to the single-channel TRNG batch collector.
- Samples NUM_CH raw TRNG bit streams and selects one channel or the XOR of all channels, with optional decimation.
- Packs accepted bits into WORD_W-bit words and stores them in a DEPTH-word buffer, in one-shot or continuous ring mode.
- Single clock domain; sits between the TRNG core and the UART dump controller, which reads via a 1-cycle-latency port.

Parameters:
- NUM_CH, 4, number of raw TRNG bit inputs
- CH_W, 2, channel-select width; NUM_CH <= 2^CH_W
- WORD_W, 8, bits per stored word
- DEPTH, 1024, buffer depth in words; need not be a power of two
- ADDR_W, 10, address width; DEPTH <= 2^ADDR_W
- DECIM_W, 8, decimation counter width

Ports:
- clk  in  1  collection/read clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; rising edge arms collection, low aborts/releases
- cfg_mode  in  1  0 = one-shot, 1 = ring (overwrite oldest)
- cfg_xor  in  1  1 = XOR of all channels, 0 = channel cfg_ch_sel
- cfg_ch_sel  in  CH_W  channel index when cfg_xor = 0
- cfg_decim  in  DECIM_W  accept 1 bit every cfg_decim+1 cycles
- cfg_count  in  ADDR_W+1  one-shot target in words; 0 or > DEPTH means DEPTH
- random_bits  in  NUM_CH  raw TRNG bits
- busy  out  1  high in COLLECT
- done  out  1  one-shot target reached
- overflow  out  1  sticky; ring mode overwrote unread data
- word_count  out  ADDR_W+1  valid words stored; saturates at DEPTH
- wr_ptr  out  ADDR_W  next write address (oldest word once overflow = 1)
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WORD_W  registered read data
- rd_valid  out  1  pulses 1 cycle after rd_en

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - busy, done, overflow, word_count, wr_ptr, rd_data and rd_valid = 0.
  - Shift register, bit counter and decimation counter = 0.
  - Buffer contents are undefined.
- start edge detection: the previous start value is registered; edge = start & ~prev.
- IDLE:
  - On edge: latch all cfg_* inputs.
  - Clear done, overflow, word_count, wr_ptr, shift register, bit counter and decimation counter.
  - Go to COLLECT. busy rises the following cycle.
- COLLECT, bit source:
  - Source bit = cfg_xor ? XOR of random_bits : random_bits[cfg_ch_sel].
  - An out-of-range ch_sel selects channel 0.
- COLLECT, decimation:
  - The decimation counter increments each cycle.
  - When it equals the latched cfg_decim, the bit is accepted and the counter returns to 0.
  - cfg_decim = 0 accepts every cycle.
- COLLECT, word packing:
  - Accepted bits shift in at the LSB, so the first bit ends up at the MSB.
  - On the WORD_W-th accepted bit, the completed word (including that bit) is written at wr_ptr in the same cycle.
  - wr_ptr advances, wrapping from DEPTH-1 to 0.
  - word_count increments, saturating at DEPTH.
- One-shot completion:
  - The write that brings word_count to the target sets done = 1.
  - State goes to DONE and no further writes occur.
- Ring mode:
  - Never completes.
  - A write while word_count == DEPTH sets overflow = 1.
  - overflow stays set until the next start edge.
- Abort: start low in COLLECT goes to IDLE next cycle.
  - The partial word is discarded.
  - word_count and wr_ptr hold their values; buffer data stays readable.
  - done stays 0.
  - If the final word write and start-low occur in the same cycle, the write and the done update complete first; abort still goes to IDLE.
- DONE: busy = 0, done = 1; start low goes to IDLE with done still 1. done clears only on the next start edge.
- Start edge while in COLLECT or DONE: impossible without start first going low; no action.
- Read port:
  - rd_en registers rd_data <= mem[rd_addr] and rd_valid = 1 on the next cycle.
  - rd_addr >= DEPTH returns 0.
  - Reading the address being written in the same cycle returns the old data.
  - Reads are legal in any state.
- Reset mid-operation aborts immediately to the reset values; the buffer is not cleared.

Test Plan:
Bench parameters: NUM_CH=4, WORD_W=8, DEPTH=16.
1. One-shot: cfg_count=4, cfg_decim=0, ch_sel=2, ch2 driven with 0xA5 pattern MSB-first → 4 writes of 0xA5 at addresses 0-3 over 32 cycles; done=1, word_count=4, busy drops; rd_addr=0-3 returns 0xA5 one cycle after rd_en.
2. XOR + decimation: cfg_xor=1, cfg_decim=2, channels chosen so XOR = 1 → first write after 24 accepted-window cycles (8 bits × 3 cycles) = 0xFF; intervening bit values are ignored.
3. Ring wrap: cfg_mode=1, 20 words written → word_count saturates at 16, wr_ptr=4, overflow=1; addresses 0-3 hold words 16-19.
4. Abort: start low after 3 words plus 5 bits → IDLE, word_count=3, done=0, no 4th write; a new start edge clears word_count and overflow.
5. cfg_count=0 or cfg_count=20 → one-shot stops at 16 words with done=1; rd_addr=17 returns 0 with rd_valid=1.
6. rst_n asserted mid-word (async, between clock edges) → all outputs 0 immediately; after release, a new start edge collects normally from address 0.
